// File: rtl/char_seq_pkg.sv
// ============================================================================
//  Module      : char_seq_pkg
//  Description : Shared types and constants for the character sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package char_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } seq_state_e;

   localparam logic [7:0] c_ESC           = 8'h1B;
   localparam logic [7:0] c_BLANK_DEFAULT = 8'h20;

endpackage

`default_nettype wire

// File: rtl/char_fifo.sv
// ============================================================================
//  Module      : char_fifo
//  Description : Single-clock FIFO with first-word-fall-through head and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module char_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             w_do_push;
   logic             w_do_pop;

   assign full  = (count_q == c_FULL);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign w_do_push = push && (!full || pop);
   assign w_do_pop  = pop && !empty;

   always_comb begin
      count_d = count_q;
      case ({w_do_push, w_do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/char_sequencer.sv
// ============================================================================
//  Module      : char_sequencer
//  Description : Queues UART bytes and shows each for a dwell time plus gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module char_sequencer
   import char_seq_pkg::*;
#(
   parameter int         DEPTH        = 16,
   parameter int         DWELL_CYCLES = 12_000_000,
   parameter int         GAP_CYCLES   = 1_200_000,
   parameter logic [7:0] BLANK_CHAR   = c_BLANK_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx_valid,
   input  logic [7:0]                 rx_data,
   output logic [7:0]                 disp_char,
   output logic                       disp_load,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       overflow
);

   localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] c_DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seq_state_e       state_q;
   logic [7:0]       disp_char_q;
   logic             disp_load_q;
   logic             busy_q;
   logic             overflow_q;
   logic [CNT_W-1:0] cnt_q;

   logic             w_esc;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_expire;
   logic [7:0]       w_head;

   assign w_esc    = rx_valid && (rx_data == c_ESC);
   assign w_push   = rx_valid && (rx_data != c_ESC);
   assign w_expire = (cnt_q == '0);

   // Pop whenever the FSM is about to move the head onto the display
   always_comb begin
      w_pop = 1'b0;
      if (!w_esc && !w_empty) begin
         case (state_q)
            ST_IDLE: w_pop = 1'b1;
            ST_SHOW: w_pop = w_expire && (GAP_CYCLES == 0);
            ST_GAP:  w_pop = w_expire;
            default: w_pop = 1'b0;
         endcase
      end
   end

   char_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (w_esc),
      .push  (w_push),
      .pop   (w_pop),
      .din   (rx_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         disp_char_q <= BLANK_CHAR;
         disp_load_q <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         cnt_q       <= '0;
      end else if (w_esc) begin
         state_q     <= ST_IDLE;
         disp_char_q <= BLANK_CHAR;
         disp_load_q <= 1'b1;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         disp_load_q <= 1'b0;
         if (w_push && w_full && !w_pop) begin
            overflow_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (!w_empty) begin
                  state_q     <= ST_SHOW;
                  busy_q      <= 1'b1;
                  disp_char_q <= w_head;
                  disp_load_q <= 1'b1;
                  cnt_q       <= c_DWELL_LOAD;
               end
            end
            ST_SHOW: begin
               if (!w_expire) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (GAP_CYCLES > 0) begin
                  state_q     <= ST_GAP;
                  disp_char_q <= BLANK_CHAR;
                  disp_load_q <= 1'b1;
                  cnt_q       <= c_GAP_LOAD;
               end else if (!w_empty) begin
                  disp_char_q <= w_head;
                  disp_load_q <= 1'b1;
                  cnt_q       <= c_DWELL_LOAD;
               end else begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  disp_char_q <= BLANK_CHAR;
                  disp_load_q <= 1'b1;
               end
            end
            ST_GAP: begin
               if (!w_expire) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!w_empty) begin
                  state_q     <= ST_SHOW;
                  disp_char_q <= w_head;
                  disp_load_q <= 1'b1;
                  cnt_q       <= c_DWELL_LOAD;
               end else begin
                  // Display is already blank, so no load strobe here
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign disp_char = disp_char_q;
   assign disp_load = disp_load_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;

endmodule

`default_nettype wire
